// File: rtl/vi_pkg.sv
// rtl/vi_pkg.sv - shared writeback request type and widths
package vi_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] addr;
    logic                  en;
    logic [XLEN-1:0]       instr;
    logic [XLEN-1:0]       pc;
  } wb_req_t;

  localparam wb_req_t WB_BUBBLE = '0;
endpackage

// File: rtl/mult_wb_fifo.sv
// rtl/mult_wb_fifo.sv - park FIFO for mult results that lost writeback arbitration
module mult_wb_fifo
  import vi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             i_push,
  input  wb_req_t          i_push_req,
  input  logic             i_pop,
  output wb_req_t          o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  // A push while full is legal only alongside a pop; the head is read before the slot is reused.
  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_req;
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push && !i_pop) assert (r_count != CNT_W'(DEPTH));
      if (i_pop) assert (r_count != '0);
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/mult_wb_merge.sv
// rtl/mult_wb_merge.sv - merges exe and mult5 results onto one writeback port
// Optional MULT_WB_PERF_EN adds stall-cycle and park-count counters.
module mult_wb_merge
  import vi_pkg::*;
#(
  parameter int XLEN  = vi_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rsn_i,
  input  logic [XLEN-1:0] exe_int_write_data_i,
  input  logic [4:0]      exe_write_addr_i,
  input  logic            exe_int_write_enable_i,
  input  logic [XLEN-1:0] exe_instruction_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic [XLEN-1:0] mult5_int_write_data_i,
  input  logic [4:0]      mult5_write_addr_i,
  input  logic            mult5_int_write_enable_i,
  input  logic [XLEN-1:0] mult5_instruction_i,
  input  logic [XLEN-1:0] mult5_pc_i,
  output logic [XLEN-1:0] wb_int_write_data_o,
  output logic [4:0]      wb_write_addr_o,
  output logic            wb_int_write_enable_o,
  output logic [XLEN-1:0] wb_instruction_o,
  output logic [XLEN-1:0] wb_pc_o,
  output logic            stall_mult_o
`ifdef MULT_WB_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_park_cnt_o
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_req_t          w_exe_req;
  wb_req_t          w_mult_req;
  wb_req_t          w_head;
  wb_req_t          w_sel;
  wb_req_t          r_wb;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  assign w_exe_req  = '{data: exe_int_write_data_i, addr: exe_write_addr_i, en: 1'b1,
                        instr: exe_instruction_i, pc: exe_pc_i};
  assign w_mult_req = '{data: mult5_int_write_data_i, addr: mult5_write_addr_i, en: 1'b1,
                        instr: mult5_instruction_i, pc: mult5_pc_i};

  // Only a full FIFO with no drain opportunity forces the mult pipe to freeze.
  assign stall_mult_o = w_full & exe_int_write_enable_i;
  assign w_accept     = mult5_int_write_enable_i & ~stall_mult_o;
  assign w_pop        = ~w_empty & ~exe_int_write_enable_i;
  assign w_push       = w_accept & (exe_int_write_enable_i | ~w_empty);

  always_comb begin
    w_sel = WB_BUBBLE;
    if (exe_int_write_enable_i) w_sel = w_exe_req;
    else if (!w_empty)          w_sel = w_head;
    else if (w_accept)          w_sel = w_mult_req;
  end

  mult_wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .i_push     (w_push),
    .i_push_req (w_mult_req),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) r_wb <= WB_BUBBLE;
    else        r_wb <= w_sel;
  end

  assign wb_int_write_data_o   = r_wb.data;
  assign wb_write_addr_o       = r_wb.addr;
  assign wb_int_write_enable_o = r_wb.en;
  assign wb_instruction_o      = r_wb.instr;
  assign wb_pc_o               = r_wb.pc;

`ifdef MULT_WB_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_park_cnt;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_stall_cnt <= '0;
      r_park_cnt  <= '0;
    end else begin
      if (stall_mult_o) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_push)       r_park_cnt  <= r_park_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
  assign perf_park_cnt_o  = r_park_cnt;
`endif
endmodule
